// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU command sequencer: in_sel codes, FSM states,
// one-hot operation selects and a one-hot test helper.
package alu_seq_pkg;

  localparam logic [2:0] IN_SEL_NONE    = 3'b000;
  localparam logic [2:0] IN_SEL_RESET   = 3'b001;
  localparam logic [2:0] IN_SEL_LOAD    = 3'b010;
  localparam logic [2:0] IN_SEL_PERSIST = 3'b100;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_LOAD = 3'd2,
    ST_HOLD = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  localparam logic [6:0] OP_SEL0 = 7'b1000000;
  localparam logic [6:0] OP_SEL1 = 7'b0100000;
  localparam logic [6:0] OP_SEL2 = 7'b0010000;
  localparam logic [6:0] OP_SEL3 = 7'b0001000;
  localparam logic [6:0] OP_SEL4 = 7'b0000100;
  localparam logic [6:0] OP_SEL5 = 7'b0000010;
  localparam logic [6:0] OP_SEL6 = 7'b0000001;

  // Callers zero-extend their select into 32 bits.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO for queued ALU commands; DEPTH must be a power of 2 (>=2).
// flush empties it in one cycle.
module alu_cmd_fifo #(
  parameter int DW    = 23,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push && !full) wr_d = wr_q + 1'b1;
    if (pop && !empty) rd_d = rd_q + 1'b1;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Drives the ALU main interface through reset -> load -> persist for each (op,a,b)
// command and returns the sampled result. Define ALU_CMD_FIFO_EN to queue commands.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NOPS     = 7,
  parameter int ALU_LAT  = 2,
  parameter int FIFO_DEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [NOPS-1:0]  cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             alu_on,
  output logic [2:0]       alu_in_sel,
  output logic [WIDTH-1:0] alu_num1,
  output logic [WIDTH-1:0] alu_num2,
  output logic [NOPS-1:0]  alu_out_sel,
  input  logic [WIDTH-1:0] alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err,
  output logic             busy
);

  localparam int CW = 2*WIDTH + NOPS;
  localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [LW-1:0] HOLD_LAST = LW'(ALU_LAT - 1);

  state_e           state_q, state_d;
  logic             on_q, on_d;
  logic [NOPS-1:0]  op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_err_q, res_err_d;
  logic             drv;

  logic             src_valid, accept;
  logic [NOPS-1:0]  src_op;
  logic [WIDTH-1:0] src_a, src_b;

  assign accept = (state_q == ST_IDLE) && src_valid && !flush;

`ifdef ALU_CMD_FIFO_EN
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_dout;

  alu_cmd_fifo #(.DW(CW), .DEPTH(FIFO_DEP)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (cmd_valid && cmd_ready),
    .din   ({cmd_op, cmd_a, cmd_b}),
    .pop   (accept),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd_ready = on_q && !fifo_full && !flush;
  assign src_valid = !fifo_empty;
  assign {src_op, src_a, src_b} = fifo_dout;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
`else
  assign cmd_ready = (state_q == ST_IDLE) && !flush;
  assign src_valid = cmd_valid;
  assign src_op    = cmd_op;
  assign src_a     = cmd_a;
  assign src_b     = cmd_b;
  assign busy      = (state_q != ST_IDLE);
`endif

  // on_q keeps every pin at 0 until the first edge after reset, so INIT is seen once.
  assign on_d        = 1'b1;
  assign alu_on      = on_q;
  assign alu_num1    = drv ? a_q  : '0;
  assign alu_num2    = drv ? b_q  : '0;
  assign alu_out_sel = drv ? op_q : '0;
  assign res_data    = res_data_q;
  assign res_err     = res_err_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    alu_in_sel = IN_SEL_NONE;
    drv        = 1'b0;
    res_valid  = 1'b0;
    case (state_q)
      ST_INIT: begin
        alu_in_sel = on_q ? IN_SEL_RESET : IN_SEL_NONE;
        if (on_q) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept) begin
          if (is_onehot(32'(src_op))) begin
            op_d    = src_op;
            a_d     = src_a;
            b_d     = src_b;
            state_d = ST_LOAD;
          end else begin
            res_err_d  = 1'b1;
            res_data_d = '0;
            state_d    = ST_RESP;
          end
        end
      end
      ST_LOAD: begin
        alu_in_sel = IN_SEL_LOAD;
        drv        = 1'b1;
        cnt_d      = '0;
        state_d    = ST_HOLD;
      end
      ST_HOLD: begin
        alu_in_sel = IN_SEL_PERSIST;
        drv        = 1'b1;
        if (cnt_q == HOLD_LAST) begin
          res_data_d = alu_out;
          res_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        res_valid = 1'b1;
        if (res_ready) begin
          res_data_d = '0;
          res_err_d  = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
    if (flush) begin
      state_d    = ST_INIT;
      op_d       = '0;
      a_d        = '0;
      b_d        = '0;
      cnt_d      = '0;
      res_data_d = '0;
      res_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      on_q       <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      on_q       <= on_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU (OP_SEL0=a+b, OP_SEL1=a-b).
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  logic       clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [6:0] cmd_op = '0;
  logic [7:0] cmd_a = '0, cmd_b = '0;
  logic       alu_on;
  logic [2:0] alu_in_sel;
  logic [7:0] alu_num1, alu_num2, alu_out;
  logic [6:0] alu_out_sel;
  logic       res_valid, res_ready = 1'b0, res_err, busy;
  logic [7:0] res_data;

  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.WIDTH(8), .NOPS(7), .ALU_LAT(2), .FIFO_DEP(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_on(alu_on), .alu_in_sel(alu_in_sel), .alu_num1(alu_num1), .alu_num2(alu_num2),
    .alu_out_sel(alu_out_sel), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .busy(busy)
  );

  // ALU model: operands captured on the LOAD cycle, result held during PERSIST.
  logic [7:0] m_a = '0, m_b = '0;
  logic [6:0] m_op = '0;
  always @(posedge clk) begin
    if (alu_in_sel == IN_SEL_LOAD) begin
      m_a  <= alu_num1;
      m_b  <= alu_num2;
      m_op <= alu_out_sel;
    end
  end
  always_comb begin
    alu_out = m_a ^ m_b;
    case (m_op)
      OP_SEL0: alu_out = m_a + m_b;
      OP_SEL1: alu_out = m_a - m_b;
      default: alu_out = m_a ^ m_b;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Enter at a negedge; return at the negedge after the accepting edge.
  task automatic send(input logic [6:0] op, input logic [7:0] a, input logic [7:0] b);
    bit ok = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (cmd_ready) ok = 1'b1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'(ok), 1);
  endtask

  task automatic wait_load();
    bit seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      if (alu_in_sel == IN_SEL_LOAD) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) chk("load_timeout", 32'(seen), 1);
  endtask

  task automatic wait_resp();
    bit seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (res_valid) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) chk("resp_timeout", 32'(seen), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // 1: reset values, then one INIT cycle, then IDLE
    repeat (2) @(negedge clk);
    chk("rst_alu_on", 32'(alu_on), 0);
    chk("rst_in_sel", 32'(alu_in_sel), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_num1", 32'(alu_num1), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("init_in_sel", 32'(alu_in_sel), 32'h1);
    chk("init_alu_on", 32'(alu_on), 1);
`ifndef ALU_CMD_FIFO_EN
    chk("init_cmd_ready", 32'(cmd_ready), 0);
`endif
    @(negedge clk);
    chk("idle_cmd_ready", 32'(cmd_ready), 1);
    chk("idle_in_sel", 32'(alu_in_sel), 0);
    chk("idle_res_valid", 32'(res_valid), 0);
    chk("idle_res_err", 32'(res_err), 0);
    chk("idle_res_data", 32'(res_data), 0);
    chk("idle_busy", 32'(busy), 0);

    // 2: 57+1A = 71
    res_ready = 1'b1;
    send(OP_SEL0, 8'h57, 8'h1A);
    wait_load();
    chk("load_in_sel", 32'(alu_in_sel), 32'h2);
    chk("load_num1", 32'(alu_num1), 32'h57);
    chk("load_num2", 32'(alu_num2), 32'h1A);
    chk("load_out_sel", 32'(alu_out_sel), 32'h40);
    @(negedge clk);
    chk("hold1_in_sel", 32'(alu_in_sel), 32'h4);
    chk("hold1_num1", 32'(alu_num1), 32'h57);
    @(negedge clk);
    chk("hold2_in_sel", 32'(alu_in_sel), 32'h4);
    @(negedge clk);
    chk("add_res_valid", 32'(res_valid), 1);
    chk("add_res_data", 32'(res_data), 32'h71);
    chk("add_res_err", 32'(res_err), 0);
    chk("resp_in_sel", 32'(alu_in_sel), 0);
    @(negedge clk);
    chk("add_done_valid", 32'(res_valid), 0);

    // 3: non-one-hot op gives an error response, ALU untouched
    send(7'b1100000, 8'h12, 8'h34);
    wait_resp();
    chk("err_res_err", 32'(res_err), 1);
    chk("err_res_data", 32'(res_data), 0);
    chk("err_in_sel", 32'(alu_in_sel), 0);
    chk("err_num1", 32'(alu_num1), 0);
    @(negedge clk);
    chk("err_done_valid", 32'(res_valid), 0);
    chk("err_done_err", 32'(res_err), 0);

    // 4: back-pressure holds the response; 50-08 = 48
    res_ready = 1'b0;
    send(OP_SEL1, 8'h50, 8'h08);
    wait_resp();
    for (int i = 0; i < 5; i++) begin
      chk("bp_res_valid", 32'(res_valid), 1);
      chk("bp_res_data", 32'(res_data), 32'h48);
`ifndef ALU_CMD_FIFO_EN
      chk("bp_cmd_ready", 32'(cmd_ready), 0);
`endif
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_done_valid", 32'(res_valid), 0);
`ifndef ALU_CMD_FIFO_EN
    chk("bp_done_cmd_ready", 32'(cmd_ready), 1);
`endif

    // 5: flush during HOLD drops the op; next command 2+4 = 6
    send(OP_SEL0, 8'h10, 8'h20);
    wait_load();
    @(negedge clk);
    chk("fl_hold_in_sel", 32'(alu_in_sel), 32'h4);
    flush = 1'b1;
    #1 chk("fl_cmd_ready", 32'(cmd_ready), 0);
    @(negedge clk);
    flush = 1'b0;
    chk("fl_init_in_sel", 32'(alu_in_sel), 32'h1);
    chk("fl_init_valid", 32'(res_valid), 0);
    begin
      logic rv = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        rv = rv | res_valid;
      end
      chk("fl_no_resp", 32'(rv), 0);
    end
    send(OP_SEL0, 8'h02, 8'h04);
    wait_resp();
    chk("fl_next_data", 32'(res_data), 32'h06);
    @(negedge clk);

    // flush beats a same-cycle accept
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_SEL0; cmd_a = 8'h01; cmd_b = 8'h01;
    flush = 1'b1;
    #1 chk("fb_cmd_ready", 32'(cmd_ready), 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    flush = 1'b0;
    chk("fb_in_sel", 32'(alu_in_sel), 32'h1);
    @(negedge clk);
    @(negedge clk);
    chk("fb_busy", 32'(busy), 0);

`ifdef ALU_CMD_FIFO_EN
    // 6: fill the queue while the response is stalled, then drain in order
    begin
      int n = 0;
      bit stop = 1'b0;
      res_ready = 1'b0;
      for (int i = 0; i < 8 && !stop; i++) begin
        cmd_valid = 1'b1; cmd_op = OP_SEL0; cmd_a = 8'(i); cmd_b = 8'h01;
        #1;
        if (!cmd_ready) stop = 1'b1;
        else begin
          n++;
          @(negedge clk);
        end
      end
      cmd_valid = 1'b0;
      chk("fifo_pushes", 32'(n), 5);
      res_ready = 1'b1;
      for (int j = 0; j < n; j++) begin
        wait_resp();
        chk("fifo_order", 32'(res_data), 32'(j + 1));
        @(negedge clk);
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
